// File: rtl/pong_pkg.sv
// Shared types for the pong match controller: FSM encodings and BCD score types.
package pong_pkg;

  localparam logic [2:0] S_NEWGAME  = 3'd0;
  localparam logic [2:0] S_PLAY     = 3'd1;
  localparam logic [2:0] S_NEWBALL  = 3'd2;
  localparam logic [2:0] S_GAMEOVER = 3'd3;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } score_t;

  function automatic score_t to_bcd(input int v);
    score_t s;
    s.tens = 4'(v / 10);
    s.ones = 4'(v % 10);
    return s;
  endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Two-digit BCD counter that saturates at 99; cnt_inc is the would-be value
// after one increment, independent of clear/inc, so callers can look ahead.
module bcd_sat_counter
  import pong_pkg::*;
(
  input  logic   clk,
  input  logic   clear,
  input  logic   inc,
  output score_t cnt,
  output score_t cnt_inc
);

  score_t cnt_q, cnt_d;

  always_comb begin
    cnt_inc = cnt_q;
    if (!(cnt_q.tens == 4'd9 && cnt_q.ones == 4'd9)) begin
      if (cnt_q.ones == 4'd9) begin
        cnt_inc.ones = 4'd0;
        cnt_inc.tens = cnt_q.tens + 4'd1;
      end else begin
        cnt_inc.ones = cnt_q.ones + 4'd1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (inc) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk) cnt_q <= cnt_d;

  assign cnt = cnt_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game/ball/wait state machine, per-player BCD scores,
// frame-based wait timer and winner/tie detection.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BALLS       = 9,
  parameter int WIN_SCORE   = 0,
  parameter int WAIT_FRAMES = 120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [NUM_PLAYERS-1:0]   up,
  input  logic [NUM_PLAYERS-1:0]   down,
  input  logic [NUM_PLAYERS-1:0]   hit,
  input  logic                     miss,
  output logic [2:0]               state,
  output logic                     gra_still,
  output logic [4:0]               balls_left,
  output logic [8*NUM_PLAYERS-1:0] score,
  output logic [1:0]               winner,
  output logic                     tie,
  output logic                     snd_hit,
  output logic                     snd_over
);

  localparam logic [4:0] BALLS_INIT = 5'(BALLS);
  localparam logic [7:0] WAIT_INIT  = 8'(WAIT_FRAMES);
  localparam score_t     WIN_BCD    = to_bcd(WIN_SCORE);

  logic [2:0] state_q, state_d;
  logic [4:0] balls_q, balls_d;
  logic [7:0] timer_q, timer_d;
  logic       gra_still_q, gra_still_d;
  logic       snd_hit_q, snd_hit_d;
  logic       snd_over_q, snd_over_d;

  score_t [NUM_PLAYERS-1:0] sc, sc_inc;
  logic   [NUM_PLAYERS-1:0] inc;
  logic btn, timer_up, win, clr;

  assign btn      = |{up, down};
  assign timer_up = (timer_q == 8'd0);
  assign inc      = (state_q == S_PLAY) ? hit : '0;

  // Look-ahead on the incremented value so the winning hit ends play immediately
  always_comb begin
    win = 1'b0;
    if (WIN_SCORE != 0)
      for (int i = 0; i < NUM_PLAYERS; i++)
        if (inc[i] && sc_inc[i] == WIN_BCD) win = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    balls_d = balls_q;
    case (state_q)
      S_NEWGAME: begin
        balls_d = BALLS_INIT;
        if (btn) begin
          state_d = S_PLAY;
          balls_d = BALLS_INIT - 5'd1;
        end
      end
      S_PLAY: begin
        if (win) state_d = S_GAMEOVER;
        else if (miss) begin
          if (balls_q == 5'd0) state_d = S_GAMEOVER;
          else begin
            state_d = S_NEWBALL;
            balls_d = balls_q - 5'd1;
          end
        end
      end
      S_NEWBALL:  if (timer_up && btn) state_d = S_PLAY;
      S_GAMEOVER: begin
        if (timer_up) begin
          state_d = S_NEWGAME;
          balls_d = BALLS_INIT;
        end
      end
      default: begin
        state_d = S_NEWGAME;
        balls_d = BALLS_INIT;
      end
    endcase
    if (reset) begin
      state_d = S_NEWGAME;
      balls_d = BALLS_INIT;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (reset)
      timer_d = 8'd0;
    else if ((state_d == S_NEWBALL || state_d == S_GAMEOVER) && state_d != state_q)
      timer_d = WAIT_INIT;
    else if (frame_tick && !timer_up)
      timer_d = timer_q - 8'd1;
  end

  assign clr         = (state_d == S_NEWGAME);
  assign gra_still_d = (state_d != S_PLAY);
  assign snd_hit_d   = !reset && (|inc);
  assign snd_over_d  = (state_d == S_GAMEOVER) && (timer_d != 8'd0);

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    balls_q     <= balls_d;
    timer_q     <= timer_d;
    gra_still_q <= gra_still_d;
    snd_hit_q   <= snd_hit_d;
    snd_over_q  <= snd_over_d;
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    bcd_sat_counter u_cnt (
      .clk     (clk),
      .clear   (clr),
      .inc     (inc[g]),
      .cnt     (sc[g]),
      .cnt_inc (sc_inc[g])
    );
  end

  // Valid BCD orders the same as binary, so scores compare directly
  always_comb begin
    score_t     best;
    logic [2:0] n_top;
    best   = sc[0];
    winner = 2'd0;
    for (int i = 1; i < NUM_PLAYERS; i++)
      if (sc[i] > best) begin
        best   = sc[i];
        winner = 2'(i);
      end
    n_top = 3'd0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (sc[i] == best) n_top = n_top + 3'd1;
    tie = (n_top > 3'd1);
  end

  assign state      = state_q;
  assign gra_still  = gra_still_q;
  assign balls_left = balls_q;
  assign score      = sc;
  assign snd_hit    = snd_hit_q;
  assign snd_over   = snd_over_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: four parameterisations share one stimulus stream,
// each tracked by an integer-level match model, plus vector table and corner cases.
module tb_pong_match_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, frame_tick, miss;
  logic [1:0] up, down, hit;

  logic [2:0]  st_o  [4];
  logic        gs_o  [4];
  logic [4:0]  bl_o  [4];
  logic [15:0] sc_o  [4];
  logic [1:0]  wn_o  [4];
  logic        tie_o [4];
  logic        sh_o  [4];
  logic        so_o  [4];

  pong_match_ctrl #(.NUM_PLAYERS(2), .BALLS(9), .WIN_SCORE(0), .WAIT_FRAMES(120)) u_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .hit(hit),
    .miss(miss), .state(st_o[0]), .gra_still(gs_o[0]), .balls_left(bl_o[0]), .score(sc_o[0]),
    .winner(wn_o[0]), .tie(tie_o[0]), .snd_hit(sh_o[0]), .snd_over(so_o[0]));
  pong_match_ctrl #(.NUM_PLAYERS(2), .BALLS(9), .WIN_SCORE(0), .WAIT_FRAMES(3)) u_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .hit(hit),
    .miss(miss), .state(st_o[1]), .gra_still(gs_o[1]), .balls_left(bl_o[1]), .score(sc_o[1]),
    .winner(wn_o[1]), .tie(tie_o[1]), .snd_hit(sh_o[1]), .snd_over(so_o[1]));
  pong_match_ctrl #(.NUM_PLAYERS(2), .BALLS(1), .WIN_SCORE(0), .WAIT_FRAMES(120)) u_c (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .hit(hit),
    .miss(miss), .state(st_o[2]), .gra_still(gs_o[2]), .balls_left(bl_o[2]), .score(sc_o[2]),
    .winner(wn_o[2]), .tie(tie_o[2]), .snd_hit(sh_o[2]), .snd_over(so_o[2]));
  pong_match_ctrl #(.NUM_PLAYERS(2), .BALLS(3), .WIN_SCORE(5), .WAIT_FRAMES(0)) u_d (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .hit(hit),
    .miss(miss), .state(st_o[3]), .gra_still(gs_o[3]), .balls_left(bl_o[3]), .score(sc_o[3]),
    .winner(wn_o[3]), .tie(tie_o[3]), .snd_hit(sh_o[3]), .snd_over(so_o[3]));

  int p_balls [4] = '{9, 9, 1, 3};
  int p_win   [4] = '{0, 0, 0, 5};
  int p_wait  [4] = '{120, 3, 120, 0};

  // Model: 0=new game, 1=play, 2=new ball, 3=game over; scores as plain integers
  int m_st [4];
  int m_bl [4];
  int m_tmr[4];
  int m_sc [4][2];
  bit m_sh [4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_step(input int k);
    bit any_btn, win;
    int ns[2];
    any_btn = ((up | down) != 2'b00);
    if (reset) begin
      m_st[k] = 0; m_bl[k] = p_balls[k]; m_tmr[k] = 0; m_sh[k] = 0;
      m_sc[k][0] = 0; m_sc[k][1] = 0;
      return;
    end
    m_sh[k] = 0;
    case (m_st[k])
      0: if (any_btn) begin m_st[k] = 1; m_bl[k] = p_balls[k] - 1; end
      1: begin
        m_sh[k] = (hit != 2'b00);
        win = 0;
        for (int p = 0; p < 2; p++) begin
          ns[p] = m_sc[k][p];
          if (hit[p]) begin
            ns[p] = (m_sc[k][p] < 99) ? m_sc[k][p] + 1 : 99;
            if (p_win[k] != 0 && ns[p] == p_win[k]) win = 1;
          end
          m_sc[k][p] = ns[p];
        end
        if (win) begin m_st[k] = 3; m_tmr[k] = p_wait[k]; end
        else if (miss) begin
          if (m_bl[k] == 0) m_st[k] = 3;
          else begin m_st[k] = 2; m_bl[k] = m_bl[k] - 1; end
          m_tmr[k] = p_wait[k];
        end
      end
      2: begin
        if (m_tmr[k] == 0 && any_btn) m_st[k] = 1;
        else if (frame_tick && m_tmr[k] > 0) m_tmr[k] = m_tmr[k] - 1;
      end
      default: begin
        if (m_tmr[k] == 0) begin
          m_st[k] = 0; m_bl[k] = p_balls[k]; m_sc[k][0] = 0; m_sc[k][1] = 0;
        end else if (frame_tick) m_tmr[k] = m_tmr[k] - 1;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] exp_v, act_v;
    int w, n;
    for (int k = 0; k < 4; k++) begin
      w = (m_sc[k][1] > m_sc[k][0]) ? 1 : 0;
      n = (m_sc[k][1] == m_sc[k][0]) ? 2 : 1;
      exp_v = {2'b00, 3'(m_st[k]), (m_st[k] != 1), 5'(m_bl[k]),
               8'(bcd(m_sc[k][1])), 8'(bcd(m_sc[k][0])), 2'(w), (n > 1),
               m_sh[k], (m_st[k] == 3 && m_tmr[k] != 0)};
      act_v = {2'b00, st_o[k], gs_o[k], bl_o[k], sc_o[k], wn_o[k], tie_o[k], sh_o[k], so_o[k]};
      chk($sformatf("model_u%0d", k), act_v, exp_v);
    end
  endtask

  task automatic step(input bit r, input logic [1:0] u, input logic [1:0] d,
                      input logic [1:0] h, input bit m, input bit t);
    reset = r; up = u; down = d; hit = h; miss = m; frame_tick = t;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) model_step(k);
    compare_all();
  endtask

  task automatic idle(); step(0, 2'b00, 2'b00, 2'b00, 0, 0); endtask

  typedef struct {
    bit         r;
    logic [1:0] u, d, h;
    bit         m, t;
    int         st, bl, s0, s1, sh;
  } vec_t;

  vec_t tbl [11];
  int   n_ticks;

  initial begin
    reset = 1'b1; up = '0; down = '0; hit = '0; miss = 1'b0; frame_tick = 1'b0;

    tbl[0]  = '{1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 9, 'h00, 'h00, 0};
    tbl[1]  = '{0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 9, 'h00, 'h00, 0};
    tbl[2]  = '{0, 2'b10, 2'b00, 2'b00, 0, 0, 1, 8, 'h00, 'h00, 0};
    tbl[3]  = '{0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 8, 'h01, 'h00, 1};
    tbl[4]  = '{0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 8, 'h02, 'h00, 1};
    tbl[5]  = '{0, 2'b00, 2'b00, 2'b01, 0, 1, 1, 8, 'h03, 'h00, 1};
    tbl[6]  = '{0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 8, 'h03, 'h00, 0};
    tbl[7]  = '{0, 2'b00, 2'b00, 2'b11, 0, 0, 1, 8, 'h04, 'h01, 1};
    tbl[8]  = '{0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 8, 'h04, 'h01, 0};
    tbl[9]  = '{0, 2'b00, 2'b00, 2'b10, 1, 0, 2, 7, 'h04, 'h02, 1};
    tbl[10] = '{0, 2'b01, 2'b00, 2'b00, 0, 1, 2, 7, 'h04, 'h02, 0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].h, tbl[i].m, tbl[i].t);
      chk($sformatf("tbl%0d_state", i), 32'(st_o[0]), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_balls", i), 32'(bl_o[0]), 32'(tbl[i].bl));
      chk($sformatf("tbl%0d_score0", i), 32'(sc_o[0][7:0]), 32'(tbl[i].s0));
      chk($sformatf("tbl%0d_score1", i), 32'(sc_o[0][15:8]), 32'(tbl[i].s1));
      chk($sformatf("tbl%0d_snd_hit", i), 32'(sh_o[0]), 32'(tbl[i].sh));
    end

    // BCD carry and saturation at 99
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    chk("bcd_09", 32'(sc_o[0][7:0]), 32'h09);
    for (int i = 0; i < 9; i++) step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    chk("bcd_18", 32'(sc_o[0][7:0]), 32'h18);
    for (int i = 0; i < 81; i++) step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    chk("bcd_99", 32'(sc_o[0][7:0]), 32'h99);
    step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    chk("sat_99", 32'(sc_o[0][7:0]), 32'h99);
    chk("sat_snd_hit", 32'(sh_o[0]), 32'd1);

    // NEWBALL wait with 3 frames: early button ignored, held button starts play
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 1, 0);
    chk("nb_enter", 32'(st_o[1]), 32'd2);
    step(0, 2'b00, 2'b00, 2'b00, 0, 1);
    step(0, 2'b10, 2'b00, 2'b00, 0, 1);
    chk("nb_tick2_ignored", 32'(st_o[1]), 32'd2);
    step(0, 2'b10, 2'b00, 2'b00, 0, 1);
    chk("nb_tick3_wait", 32'(st_o[1]), 32'd2);
    step(0, 2'b10, 2'b00, 2'b00, 0, 0);
    chk("nb_held_play", 32'(st_o[1]), 32'd1);

    // Reset in the middle of a NEWBALL wait
    step(0, 2'b00, 2'b00, 2'b00, 1, 0);
    chk("rst_mid_nb", 32'(st_o[1]), 32'd2);
    step(0, 2'b00, 2'b00, 2'b00, 0, 1);
    step(1, 2'b11, 2'b11, 2'b11, 1, 1);
    chk("rst_state", 32'(st_o[1]), 32'd0);
    chk("rst_balls", 32'(bl_o[1]), 32'd9);
    chk("rst_still", 32'(gs_o[1]), 32'd1);

    // Single ball game: game over tone lasts 120 frame ticks
    step(0, 2'b00, 2'b01, 2'b00, 0, 0);
    chk("c_balls0", 32'(bl_o[2]), 32'd0);
    step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    step(0, 2'b00, 2'b00, 2'b10, 0, 0);
    step(0, 2'b00, 2'b00, 2'b01, 1, 0);
    chk("c_gameover", 32'(st_o[2]), 32'd3);
    chk("c_snd_over", 32'(so_o[2]), 32'd1);
    chk("c_winner", 32'(wn_o[2]), 32'd0);
    n_ticks = 0;
    for (int c = 0; c < 400; c++) begin
      step(0, 2'b00, 2'b00, 2'b00, 0, 1);
      n_ticks++;
      if (!so_o[2]) break;
    end
    chk("c_over_ticks", 32'(n_ticks), 32'd120);
    idle();
    chk("c_newgame", 32'(st_o[2]), 32'd0);
    chk("c_scores_clr", 32'(sc_o[2]), 32'h0000);

    // WIN_SCORE=5: winning hit beats a simultaneous miss; WAIT_FRAMES=0
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    step(0, 2'b00, 2'b00, 2'b11, 1, 0);
    chk("win_gameover", 32'(st_o[3]), 32'd3);
    chk("win_balls", 32'(bl_o[3]), 32'd2);
    chk("win_winner", 32'(wn_o[3]), 32'd0);
    chk("win_tie", 32'(tie_o[3]), 32'd0);
    chk("win_scores", 32'(sc_o[3]), 32'h0105);
    chk("win_no_tone", 32'(so_o[3]), 32'd0);
    idle();
    chk("win_newgame", 32'(st_o[3]), 32'd0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 1, 0);
    chk("w0_newball", 32'(st_o[3]), 32'd2);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    chk("w0_replay", 32'(st_o[3]), 32'd1);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0);
    chk("tie_flag", 32'(tie_o[3]), 32'd1);
    chk("tie_winner", 32'(wn_o[3]), 32'd0);
    step(0, 2'b00, 2'b00, 2'b10, 0, 0);
    chk("lead_winner", 32'(wn_o[3]), 32'd1);
    chk("lead_tie", 32'(tie_o[3]), 32'd0);

    // Random traffic, all four instances checked against the model every cycle
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 299) == 0),
           {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
           {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
           {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2 (legal 2..4), meaning number of paddles and score channels.
REQ-002 SHALL have parameter BALLS, default 9 (legal 1..31), meaning balls per game.
REQ-003 SHALL have parameter WIN_SCORE, default 0 (legal 0..99), meaning score that ends the game early; 0 disables early ending.
REQ-004 SHALL have parameter WAIT_FRAMES, default 120 (legal 0..255), meaning frame ticks waited after a miss and at game over.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports clk, reset.
REQ-006 clk  input  1  system clock (100 MHz).
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 up, down  input  NUM_PLAYERS each  paddle buttons, one bit per player, level.
REQ-010 hit  input  NUM_PLAYERS  one-cycle pulse per player paddle hit.
REQ-011 miss  input  1  one-cycle pulse, ball left the field.
REQ-012 state  output  3  current state encoding.
REQ-013 gra_still  output  1  freeze ball/paddle animation.
REQ-014 balls_left  output  5  remaining balls, binary.
REQ-015 score  output  8*NUM_PLAYERS  two BCD digits per player, player 0 in bits [7:0], tens digit in the upper nibble.
REQ-016 winner  output  2  index of the highest-scoring player; valid in GAME_OVER.
REQ-017 tie  output  1  high in GAME_OVER when two or more players share the top score.
REQ-018 snd_hit  output  1  one-cycle pulse per accepted hit.
REQ-019 snd_over  output  1  game-over tone enable.

Function
REQ-020 SHALL implement the states NEWGAME=0, PLAY=1, NEWBALL=2, GAMEOVER=3; encodings 4..7 SHALL go to NEWGAME on the next cycle.
REQ-021 NEWGAME: gra_still=1, balls_left held at BALLS, all scores held at 00; any up/down bit high -> PLAY next cycle and balls_left=BALLS-1.
REQ-022 PLAY: gra_still=0; each hit[i] pulse SHALL increment score[i] by 1 BCD, visible the next cycle; simultaneous hits to different players SHALL all be counted.
REQ-023 Score SHALL saturate at 99; a hit at 99 SHALL still pulse snd_hit.
REQ-024 snd_hit SHALL pulse for one cycle, on the cycle after any accepted hit (OR of all hit bits) in PLAY; hits in other states SHALL be ignored.
REQ-025 miss in PLAY with balls_left==0 -> GAMEOVER; otherwise -> NEWBALL with balls_left decremented by 1; no underflow.
REQ-026 If the post-increment score of any player equals WIN_SCORE (WIN_SCORE!=0) -> GAMEOVER the next cycle; this SHALL take priority over a miss in the same cycle.
REQ-027 hit and miss in the same cycle: the hit SHALL be scored and the miss SHALL then be processed.
REQ-028 Wait timer (8 bit) SHALL load WAIT_FRAMES on entry to NEWBALL or GAMEOVER and decrement on each frame_tick until 0; timer_up = (count==0).
REQ-029 NEWBALL: gra_still=1; timer_up and any button -> PLAY; buttons before timer_up SHALL be ignored; a button held at expiry SHALL start play.
REQ-030 GAMEOVER: gra_still=1, snd_over=1 while !timer_up; timer_up -> NEWGAME with snd_over=0.
REQ-031 winner/tie SHALL be computed combinationally from the scores; ties SHALL report the lowest index in winner.
REQ-032 With WAIT_FRAMES=0 the timer SHALL be expired on state entry.

Reset
REQ-033 reset SHALL force state=NEWGAME, balls_left=BALLS, all scores=00, timer=0, snd_hit=0, snd_over=0, gra_still=1 on the next clk edge, overriding every other input, including mid-game and mid-wait.

Structure
REQ-034 State encodings, BCD digit type and the 8-bit score type SHALL live in the shared package pong_pkg.
REQ-035 Per-player score SHALL be a generate-replicated sub-module bcd_sat_counter (clear, inc, two-digit saturating output).
REQ-036 All outputs except winner/tie SHALL be registered; no latches.

Verification
REQ-037 Reset, press up[1] -> PLAY, balls_left=8; 3 hit[0] pulses -> score[7:0]=0x03, 3 snd_hit pulses.
REQ-038 hit=2'b11 in one cycle -> both scores +1, a single snd_hit pulse.
REQ-039 Nine hits to player 0 from 0x09 -> 0x18; with score at 0x99, a hit -> stays 0x99 and snd_hit pulses.
REQ-040 miss with WAIT_FRAMES=3 -> NEWBALL; button at frame tick 2 is ignored; button held at tick 3 -> PLAY.
REQ-041 BALLS=1, press button, then miss -> GAMEOVER, snd_over=1 for 120 frame ticks, then NEWGAME with scores 00; WIN_SCORE=5, fifth hit coinciding with a miss -> GAMEOVER, winner=0.
REQ-042 reset asserted during NEWBALL wait -> NEWGAME next cycle, timer=0, balls_left=BALLS.
